pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 8-bit pipelined CPU. Watches the decode/execute and execute/memory pipeline registers and drives the stall, flush and PC-write enables. Handles:
- RAW hazards
- taken-branch flushes
- multi-cycle data-memory waits with timeout
- halt

Sits beside the stage registers; every stage register's enable and clear comes from this block.

Parameters:
REG_ADDR_W, 5, register-address width.
BRANCH_PENALTY, 2, cycles of flush_id after a taken branch (legal range 1..7).
MEM_TIMEOUT, 15, MEM_WAIT cycles before timeout (legal range 1..255).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous active-high reset.
id_r_reg1  input  REG_ADDR_W  source reg 1 of the instruction in decode.
id_r_reg2  input  REG_ADDR_W  source reg 2 of the instruction in decode.
id_uses_rs1  input  1  decode instruction reads rs1.
id_uses_rs2  input  1  decode instruction reads rs2.
ex_wr_reg  input  REG_ADDR_W  destination of the instruction in execute.
ex_reg_write  input  1  execute instruction writes a register.
ex_is_load  input  1  execute instruction is a load.
mem_wr_reg  input  REG_ADDR_W  destination of the instruction in memory stage.
mem_reg_write  input  1  memory-stage instruction writes a register.
branch_taken  input  1  execute resolved a taken branch/jump.
mem_req  input  1  execute/memory issues a data-memory access.
mem_ack  input  1  data memory completes the access.
halt_req  input  1  halt opcode reached execute.
resume  input  1  leave HALT.
pc_write  output  1  PC update enable.
stall_if  output  1  hold fetch/decode register.
stall_id  output  1  hold decode/execute register.
stall_ex  output  1  hold execute/memory register.
flush_id  output  1  clear fetch/decode register (bubble).
flush_ex  output  1  clear decode/execute register (bubble).
fwd_a  output  2  operand-A source: 00 regfile, 01 EX result, 10 MEM result.
fwd_b  output  2  operand-B source, same encoding.
halted  output  1  controller in HALT.
mem_timeout  output  1  sticky error flag.

Behaviour:
- Reset values: state=RUN, counters 0, mem_timeout=0. While rst=1, outputs are forced regardless of inputs:
  - pc_write=1
  - all stall/flush=0
  - fwd_a/fwd_b=00
  - halted=0
- States: RUN, BR_FLUSH, MEM_WAIT, HALT. Outputs are combinational from state and inputs. State and counters are registered.
- Match definition:
  - src matches EX = uses_rsN & ex_reg_write & ex_wr_reg!=0 & ex_wr_reg==id_r_regN.
  - Same form for MEM.
  - Register 0 never matches.
- Priority in RUN (highest first):
  1. halt_req: flush_ex=1, pc_write=0, next HALT.
  2. mem_req & !mem_ack: stall_if=stall_id=stall_ex=1, pc_write=0, next MEM_WAIT, wait counter cleared.
  3. branch_taken: flush_id=flush_ex=1, pc_write=1. Next BR_FLUSH if BRANCH_PENALTY>1, else RUN.
  4. Data hazard (see Optional Feature): stall_if=stall_id=1, pc_write=0, flush_ex=1, for exactly that cycle. State stays RUN.
- mem_req & mem_ack in the same cycle: zero-wait access, no stall.
- BR_FLUSH:
  - flush_id=1, pc_write=1 for BRANCH_PENALTY-1 cycles (down-counter), then RUN.
  - A new branch_taken reloads the counter.
  - halt_req preempts BR_FLUSH.
- MEM_WAIT:
  - All stalls=1, pc_write=0. The counter increments each cycle.
  - mem_ack returns to RUN next cycle, releasing all stalls.
  - When the counter reaches MEM_TIMEOUT without ack: set mem_timeout (sticky until rst), next HALT.
  - branch_taken and halt_req are ignored in MEM_WAIT. They are held by the stalled execute stage and evaluated on return to RUN.
- HALT:
  - halted=1, pc_write=0, all stalls=1.
  - resume returns to RUN, except when mem_timeout=1 (then only rst exits).
- Reset asserted mid-stall or mid-flush: immediate return to reset values; no pending flush survives.

Optional Feature:
FORWARD_EN:
- Defined:
  - fwd_a/fwd_b select EX (01) on an EX match, else MEM (10) on a MEM match, else 00. EX wins over MEM.
  - Only load-use (EX match & ex_is_load) is a data hazard and stalls, for 1 cycle.
- Undefined:
  - fwd_a=fwd_b=00 always.
  - Any EX or MEM match is a data hazard. Stalls repeat each cycle until no match remains (2 cycles for an EX match).

Test Plan:
- Reset release, no hazards, 10 cycles: pc_write=1 every cycle, all stalls/flushes 0.
- ex_is_load=1, ex_wr_reg=3, id_r_reg1=3, id_uses_rs1=1: one cycle of stall_if=stall_id=flush_ex=1, pc_write=0. FORWARD_EN: fwd_a=10 the next cycle.
- FORWARD_EN, ALU op with ex_wr_reg=5, id_r_reg2=5: fwd_b=01, no stall. Same with register 0: fwd_b=00. Without FORWARD_EN: 2 stall cycles.
- branch_taken for 1 cycle, BRANCH_PENALTY=2: flush_id=1 for 2 cycles, flush_ex=1 for the first cycle only. Second branch in the flush window reloads the counter.
- mem_req=1 with mem_ack after 4 cycles: 4 stall cycles, then release. mem_ack never arrives, MEM_TIMEOUT=15: mem_timeout=1 and halted=1 after 15 cycles, resume ignored, rst clears.
- halt_req and branch_taken in the same cycle: HALT entered, no BR_FLUSH. resume: RUN next cycle, pc_write=1. rst during MEM_WAIT: all outputs at reset values immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for the 8-bit pipelined CPU. It watches the
// decode/execute and execute/memory pipeline registers and produces every
// stage-register enable/clear plus the PC write enable. It handles RAW hazards,
// taken-branch flushes, multi-cycle data-memory waits with a timeout, and halt.
//
// Build option:
//   FORWARD_EN  defined   : EX/MEM forwarding is active. Only a load-use
//                           pair stalls, and only for one cycle.
//               undefined : no forwarding (fwd_a/fwd_b = 00). Any EX or MEM
//                           match stalls until the producer has retired.
//
// Parameters:
//   REG_ADDR_W      register-address width
//   BRANCH_PENALTY  cycles of flush_id after a taken branch (1..7)
//   MEM_TIMEOUT     MEM_WAIT cycles before the timeout error (1..255)
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   id_r_reg1/2, id_uses_rs1/2  decode-stage source registers and their use
//   ex_wr_reg, ex_reg_write, ex_is_load   execute-stage destination
//   mem_wr_reg, mem_reg_write             memory-stage destination
//   branch_taken              execute resolved a taken branch/jump
//   mem_req, mem_ack          data-memory handshake
//   halt_req, resume          enter / leave HALT
//   pc_write                  PC update enable
//   stall_if/id/ex            hold IF/ID, ID/EX, EX/MEM registers
//   flush_id/ex               clear IF/ID, ID/EX registers (bubble)
//   fwd_a/fwd_b               operand source: 00 regfile, 01 EX, 10 MEM
//   halted                    controller is in HALT
//   mem_timeout               sticky memory-timeout error (cleared by rst)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W     = 5,
  parameter int BRANCH_PENALTY = 2,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_r_reg1,
  input  logic [REG_ADDR_W-1:0] id_r_reg2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_wr_reg,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] mem_wr_reg,
  input  logic                  mem_reg_write,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  pc_write,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  halted,
  output logic                  mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_e;

  localparam logic [2:0] BR_RELOAD    = 3'(BRANCH_PENALTY - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [1:0] FWD_RF       = 2'b00;
  localparam logic [1:0] FWD_EX       = 2'b01;
  localparam logic [1:0] FWD_MEM      = 2'b10;

  state_e     state_q, state_d;
  logic [2:0] br_cnt_q, br_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  // ---------------------------------------------------------------------------
  // Operand match detection. Register 0 is hard-wired zero and never matches.
  // ---------------------------------------------------------------------------
  logic ex_match_a, ex_match_b, mem_match_a, mem_match_b;
  logic data_hazard;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  assign ex_match_a  = id_uses_rs1 & ex_reg_write  & (ex_wr_reg  != '0) & (ex_wr_reg  == id_r_reg1);
  assign ex_match_b  = id_uses_rs2 & ex_reg_write  & (ex_wr_reg  != '0) & (ex_wr_reg  == id_r_reg2);
  assign mem_match_a = id_uses_rs1 & mem_reg_write & (mem_wr_reg != '0) & (mem_wr_reg == id_r_reg1);
  assign mem_match_b = id_uses_rs2 & mem_reg_write & (mem_wr_reg != '0) & (mem_wr_reg == id_r_reg2);

`ifdef FORWARD_EN
  // EX is the younger producer, so it wins over MEM.
  assign fwd_a_sel   = ex_match_a ? FWD_EX : (mem_match_a ? FWD_MEM : FWD_RF);
  assign fwd_b_sel   = ex_match_b ? FWD_EX : (mem_match_b ? FWD_MEM : FWD_RF);
  // Load data only exists after the memory stage: the one case forwarding
  // cannot cover.
  assign data_hazard = (ex_match_a | ex_match_b) & ex_is_load;
`else
  assign fwd_a_sel   = FWD_RF;
  assign fwd_b_sel   = FWD_RF;
  // Without forwarding, load-use is just one case of an EX match; every
  // pending write to a source register must retire before decode proceeds.
  assign data_hazard = ((ex_match_a | ex_match_b) & ex_is_load)
                     | ex_match_a | ex_match_b | mem_match_a | mem_match_b;
`endif

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      br_cnt_q   <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      br_cnt_q   <= br_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d    = state_q;
    br_cnt_d   = br_cnt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    pc_write   = 1'b1;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    halted     = 1'b0;
    fwd_a      = fwd_a_sel;
    fwd_b      = fwd_b_sel;

    unique case (state_q)
      RUN: begin
        if (halt_req) begin
          // Kill whatever follows the halt opcode and freeze the PC.
          flush_ex = 1'b1;
          pc_write = 1'b0;
          state_d  = HALT;
        end else if (mem_req && !mem_ack) begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          stall_ex   = 1'b1;
          pc_write   = 1'b0;
          wait_cnt_d = '0;
          state_d    = MEM_WAIT;
        end else if (branch_taken) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            br_cnt_d = BR_RELOAD;
            state_d  = BR_FLUSH;
          end
        end else if (data_hazard) begin
          // Hold fetch/decode and inject a bubble into execute; re-evaluated
          // every cycle, so multi-cycle hazards stall repeatedly.
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
          pc_write = 1'b0;
        end
      end

      BR_FLUSH: begin
        if (halt_req) begin
          flush_ex = 1'b1;
          pc_write = 1'b0;
          state_d  = HALT;
        end else if (branch_taken) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
          br_cnt_d = BR_RELOAD;
        end else begin
          flush_id = 1'b1;
          br_cnt_d = br_cnt_q - 3'd1;
          if (br_cnt_q <= 3'd1) begin
            state_d = RUN;
          end
        end
      end

      MEM_WAIT: begin
        // branch_taken/halt_req are held by the stalled execute stage and
        // are picked up again once RUN resumes.
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
        pc_write = 1'b0;
        if (mem_ack) begin
          state_d = RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == TIMEOUT_LAST) begin
            timeout_d = 1'b1;
            state_d   = HALT;
          end
        end
      end

      HALT: begin
        halted   = 1'b1;
        pc_write = 1'b0;
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
        // A timeout is fatal: only rst leaves HALT.
        if (resume && !timeout_q) begin
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase

    // While rst is high the stage controls are forced, whatever the inputs.
    if (rst) begin
      pc_write = 1'b1;
      stall_if = 1'b0;
      stall_id = 1'b0;
      stall_ex = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      fwd_a    = FWD_RF;
      fwd_b    = FWD_RF;
      halted   = 1'b0;
    end
  end

  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pipeline_hazard_ctrl (default parameters: BRANCH_PENALTY=2,
// MEM_TIMEOUT=15). Inputs change on the falling edge; outputs are sampled 1 ns
// later, i.e. they reflect the state registered at the preceding rising edge
// plus the inputs of the current cycle. Expectations follow the FORWARD_EN
// build setting.
//
// Output vector layout (12 bits):
//   [11] pc_write [10] stall_if [9] stall_id [8] stall_ex [7] flush_id
//   [6] flush_ex [5:4] fwd_a [3:2] fwd_b [1] halted [0] mem_timeout
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [4:0] id_r_reg1;
    logic [4:0] id_r_reg2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_wr_reg;
    logic       ex_reg_write;
    logic       ex_is_load;
    logic [4:0] mem_wr_reg;
    logic       mem_reg_write;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_ack;
    logic       halt_req;
    logic       resume;
  } stim_t;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [11:0] E_RUN     = 12'h800;
  localparam logic [11:0] E_HAZ     = 12'h640;
  localparam logic [11:0] E_MEMSTL  = 12'h700;
  localparam logic [11:0] E_BR      = 12'h8C0;
  localparam logic [11:0] E_BRF     = 12'h880;
  localparam logic [11:0] E_HALTIN  = 12'h040;
  localparam logic [11:0] E_HALT    = 12'h702;
  localparam logic [11:0] E_HALT_TO = 12'h703;
  localparam logic [11:0] FA_EX     = 12'h010;
  localparam logic [11:0] FA_MEM    = 12'h020;
  localparam logic [11:0] FB_EX     = 12'h004;
  localparam logic [11:0] FB_MEM    = 12'h008;

  logic clk = 1'b0;
  logic rst = 1'b1;
  stim_t s = '0;

  logic pc_write, stall_if, stall_id, stall_ex, flush_id, flush_ex;
  logic [1:0] fwd_a, fwd_b;
  logic halted, mem_timeout;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5),
    .BRANCH_PENALTY(2),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_r_reg1    (s.id_r_reg1),
    .id_r_reg2    (s.id_r_reg2),
    .id_uses_rs1  (s.id_uses_rs1),
    .id_uses_rs2  (s.id_uses_rs2),
    .ex_wr_reg    (s.ex_wr_reg),
    .ex_reg_write (s.ex_reg_write),
    .ex_is_load   (s.ex_is_load),
    .mem_wr_reg   (s.mem_wr_reg),
    .mem_reg_write(s.mem_reg_write),
    .branch_taken (s.branch_taken),
    .mem_req      (s.mem_req),
    .mem_ack      (s.mem_ack),
    .halt_req     (s.halt_req),
    .resume       (s.resume),
    .pc_write     (pc_write),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .stall_ex     (stall_ex),
    .flush_id     (flush_id),
    .flush_ex     (flush_ex),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .halted       (halted),
    .mem_timeout  (mem_timeout)
  );

  assign obs = {pc_write, stall_if, stall_id, stall_ex, flush_id, flush_ex,
                fwd_a, fwd_b, halted, mem_timeout};

  // Control-only stimulus: branch, mem_req, mem_ack, halt_req, resume.
  function automatic stim_t ctl(input logic br, input logic mreq, input logic mack,
                                input logic hlt, input logic res);
    stim_t v = '0;
    v.branch_taken = br;
    v.mem_req      = mreq;
    v.mem_ack      = mack;
    v.halt_req     = hlt;
    v.resume       = res;
    return v;
  endfunction

  // Register-dependency stimulus.
  function automatic stim_t hz(input logic [4:0] r1, input logic [4:0] r2,
                               input logic u1, input logic u2,
                               input logic [4:0] exr, input logic exw, input logic exl,
                               input logic [4:0] memr, input logic memw);
    stim_t v = '0;
    v.id_r_reg1     = r1;
    v.id_r_reg2     = r2;
    v.id_uses_rs1   = u1;
    v.id_uses_rs2   = u2;
    v.ex_wr_reg     = exr;
    v.ex_reg_write  = exw;
    v.ex_is_load    = exl;
    v.mem_wr_reg    = memr;
    v.mem_reg_write = memw;
    return v;
  endfunction

  task automatic test_reset();
    // Hostile inputs while reset is held: outputs must stay at reset values.
    rst = 1'b1;
    s   = '1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== E_RUN) begin
      errors++;
      $display("FAIL reset_forced: got %h expected %h", obs, E_RUN);
    end
    @(negedge clk);
    s   = '0;
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== E_RUN) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs, E_RUN);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s = '0;
      #1;
      checks++;
      if (obs !== E_RUN) begin
        errors++;
        $display("FAIL idle[%0d]: got %h expected %h", i, obs, E_RUN);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t       sv[5];
    logic [11:0] ev[5];
    sv[0] = hz(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0);
    ev[0] = E_HAZ | (FWD ? FA_EX : 12'h000);
    // The load has moved on to MEM, a bubble sits in EX.
    sv[1] = hz(5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1);
    ev[1] = FWD ? (E_RUN | FA_MEM) : E_HAZ;
    sv[2] = '0;
    ev[2] = E_RUN;
    // Load to r3, but decode does not read rs1.
    sv[3] = hz(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0);
    ev[3] = E_RUN;
    // Load-use through operand B.
    sv[4] = hz(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0);
    ev[4] = E_HAZ | (FWD ? FB_EX : 12'h000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s = sv[i];
      #1;
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL load_use[%0d]: got %h expected %h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_alu_forward();
    stim_t       sv[6];
    logic [11:0] ev[6];
    sv[0] = hz(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    ev[0] = FWD ? (E_RUN | FB_EX) : E_HAZ;
    sv[1] = hz(5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    ev[1] = FWD ? (E_RUN | FB_MEM) : E_HAZ;
    sv[2] = '0;
    ev[2] = E_RUN;
    // Both stages write r5: EX has priority.
    sv[3] = hz(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1);
    ev[3] = FWD ? (E_RUN | FA_EX | FB_EX) : E_HAZ;
    // Register 0 never matches.
    sv[4] = hz(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1);
    ev[4] = E_RUN;
    // Same address but EX does not write a register.
    sv[5] = hz(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0);
    ev[5] = E_RUN;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s = sv[i];
      #1;
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL alu_forward[%0d]: got %h expected %h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_branch();
    stim_t       sv[7];
    logic [11:0] ev[7];
    sv[0] = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  ev[0] = E_BR;
    sv[1] = '0;                                  ev[1] = E_BRF;
    sv[2] = '0;                                  ev[2] = E_RUN;
    sv[3] = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  ev[3] = E_BR;
    // Second branch inside the flush window reloads the counter.
    sv[4] = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  ev[4] = E_BR;
    sv[5] = '0;                                  ev[5] = E_BRF;
    sv[6] = '0;                                  ev[6] = E_RUN;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s = sv[i];
      #1;
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL branch[%0d]: got %h expected %h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t       sv[6];
    logic [11:0] ev[6];
    sv[0] = ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  ev[0] = E_RUN;     // zero-wait
    sv[1] = ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  ev[1] = E_MEMSTL;  // enter wait
    sv[2] = ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  ev[2] = E_MEMSTL;
    sv[3] = ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);  ev[3] = E_MEMSTL;  // br/halt ignored
    sv[4] = ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  ev[4] = E_MEMSTL;  // ack
    sv[5] = '0;                                  ev[5] = E_RUN;     // released
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s = sv[i];
      #1;
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got %h expected %h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_timeout();
    // Entry cycle plus 15 MEM_WAIT cycles without ack, then HALT with error.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s = ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (obs !== E_MEMSTL) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got %h expected %h", i, obs, E_MEMSTL);
      end
    end
    @(negedge clk);
    s = ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (obs !== E_HALT_TO) begin
      errors++;
      $display("FAIL timeout_halt: got %h expected %h", obs, E_HALT_TO);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      checks++;
      if (obs !== E_HALT_TO) begin
        errors++;
        $display("FAIL timeout_resume[%0d]: got %h expected %h", i, obs, E_HALT_TO);
      end
    end
    @(negedge clk);
    s   = '0;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== E_RUN) begin
      errors++;
      $display("FAIL timeout_rst: got %h expected %h", obs, E_RUN);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== E_RUN) begin
      errors++;
      $display("FAIL timeout_after_rst: got %h expected %h", obs, E_RUN);
    end
  endtask

  task automatic test_halt();
    stim_t       sv[10];
    logic [11:0] ev[10];
    sv[0] = ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  ev[0] = E_HALTIN;  // halt beats branch
    sv[1] = '0;                                  ev[1] = E_HALT;
    sv[2] = '0;                                  ev[2] = E_HALT;
    sv[3] = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  ev[3] = E_HALT;
    sv[4] = '0;                                  ev[4] = E_RUN;
    sv[5] = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  ev[5] = E_BR;
    sv[6] = ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);  ev[6] = E_HALTIN;  // preempts BR_FLUSH
    sv[7] = '0;                                  ev[7] = E_HALT;
    sv[8] = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  ev[8] = E_HALT;
    sv[9] = '0;                                  ev[9] = E_RUN;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s = sv[i];
      #1;
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL halt[%0d]: got %h expected %h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t       sv[7];
    logic        rv[7];
    logic [11:0] ev[7];
    sv[0] = ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  rv[0] = 1'b0;  ev[0] = E_MEMSTL;
    sv[1] = ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  rv[1] = 1'b0;  ev[1] = E_MEMSTL;
    sv[2] = ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  rv[2] = 1'b1;  ev[2] = E_RUN;
    sv[3] = '0;                                  rv[3] = 1'b0;  ev[3] = E_RUN;
    sv[4] = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  rv[4] = 1'b0;  ev[4] = E_BR;
    sv[5] = '0;                                  rv[5] = 1'b1;  ev[5] = E_RUN;
    sv[6] = '0;                                  rv[6] = 1'b0;  ev[6] = E_RUN;  // no flush left
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s   = sv[i];
      rst = rv[i];
      #1;
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %h expected %h", i, obs, ev[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_use();
    test_alu_forward();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_reset_mid();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
